// File: rtl/fetch_unit_rv32.sv
// fetch_unit_rv32: RV32 instruction fetch stage.
// Drives the sequential fetch address to the instruction cache and keeps at
// most one request outstanding. Each cache response is paired with its PC in
// a small skid FIFO that feeds decode through a valid/stall handshake.
// A redirect from execute flushes everything and restarts fetch at the
// (word-aligned) target.

module fetch_unit_rv32 #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic [31:0] oINSTADDR,
  input  logic [31:0] iINSTDATA,
  input  logic        iStallI,
  input  logic        iREDIRECT,
  input  logic [31:0] iREDIRECTPC,
  input  logic        iStallD,
  output logic        oVALID,
  output logic [31:0] oINSTR,
  output logic [31:0] oPC,
  output logic        oMISALIGN
);

  // Storage is sized for the largest legal depth; pointers wrap at FIFO_DEPTH.
  localparam int unsigned MAX_DEPTH = 4;
  localparam logic [2:0]  DEPTH     = 3'(FIFO_DEPTH);
  localparam logic [1:0]  LAST_IDX  = 2'(FIFO_DEPTH - 1);

  // Advance a FIFO pointer, wrapping after the last used entry.
  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    logic [1:0] nxt;
    if (ptr == LAST_IDX) begin
      nxt = 2'd0;
    end else begin
      nxt = ptr + 2'd1;
    end
    return nxt;
  endfunction

  // Fetch-side state
  logic [31:0] pc_q,       pc_d;
  logic        req_v_q,    req_v_d;
  logic [31:0] req_pc_q,   req_pc_d;
  logic        misalign_q, misalign_d;

  // FIFO bookkeeping
  logic [1:0]  rd_ptr_q,   rd_ptr_d;
  logic [1:0]  wr_ptr_q,   wr_ptr_d;
  logic [2:0]  occ_q,      occ_d;

  // FIFO storage (data path, no reset needed: occupancy qualifies it)
  logic [31:0] fifo_pc_q    [MAX_DEPTH];
  logic [31:0] fifo_instr_q [MAX_DEPTH];

  // Per-cycle handshake terms
  logic        resp_s;
  logic        deq_s;
  logic        issue_s;
  logic        wr_en_s;
  logic [2:0]  occ_next_s;
  logic [31:0] addr_sel_s;

  // Handshake terms: response capture, dequeue and credit-gated issue.
  always_comb begin
    resp_s     = req_v_q & ~iStallI;
    deq_s      = (occ_q != 3'd0) & ~iStallD;
    // deq_s implies occ_q >= 1, so this never underflows.
    occ_next_s = occ_q + {2'b00, resp_s} - {2'b00, deq_s};
    // A new request is only sent when its response is guaranteed a slot,
    // so a response can never arrive into a full FIFO.
    issue_s    = ~iREDIRECT & ~(req_v_q & ~resp_s) & (occ_next_s < DEPTH);
  end

  // Next-state logic for PC, outstanding request and FIFO pointers.
  always_comb begin
    pc_d       = pc_q;
    req_v_d    = req_v_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    misalign_d = 1'b0;
    wr_en_s    = 1'b0;

    if (iREDIRECT) begin
      // Flush: drop buffered entries, the outstanding request and any
      // response arriving this cycle; restart at the aligned target.
      pc_d       = {iREDIRECTPC[31:2], 2'b00};
      req_v_d    = 1'b0;
      occ_d      = 3'd0;
      rd_ptr_d   = 2'd0;
      wr_ptr_d   = 2'd0;
      misalign_d = (iREDIRECTPC[1:0] != 2'b00);
    end else begin
      occ_d = occ_next_s;

      if (resp_s) begin
        wr_en_s  = 1'b1;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (deq_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      if (issue_s) begin
        req_v_d  = 1'b1;
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;  // wraps 32'hFFFF_FFFC -> 0 naturally
      end else if (resp_s) begin
        req_v_d  = 1'b0;
      end else begin
        // Either idle or the cache stalled: keep the request as is.
        req_v_d  = req_v_q;
      end
    end
  end

  // Control registers with synchronous reset; reset beats redirect.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pc_q       <= RESET_PC;
      req_v_q    <= 1'b0;
      req_pc_q   <= RESET_PC;
      rd_ptr_q   <= 2'd0;
      wr_ptr_q   <= 2'd0;
      occ_q      <= 3'd0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_v_q    <= req_v_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      misalign_q <= misalign_d;
    end
  end

  // FIFO write port: store the response together with the PC it belongs to.
  always_ff @(posedge iCLK) begin
    if (wr_en_s) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      fifo_instr_q[wr_ptr_q] <= iINSTDATA;
    end
  end

  // Cache address: re-present a stalled request, otherwise the next PC.
  always_comb begin
    if (req_v_q & ~resp_s) begin
      addr_sel_s = req_pc_q;
    end else begin
      addr_sel_s = pc_q;
    end
    oINSTADDR = {2'b00, addr_sel_s[31:2]};
  end

  // Decode-side outputs come straight from the FIFO head and registers.
  always_comb begin
    oVALID    = (occ_q != 3'd0);
    oPC       = fifo_pc_q[rd_ptr_q];
    oINSTR    = fifo_instr_q[rd_ptr_q];
    oMISALIGN = misalign_q;
  end

  fetch_unit_rv32_chk #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_chk (
    .clk (iCLK),
    .rst (iRST),
    .occ (occ_q)
  );

endmodule

// Property checker for the fetch buffer occupancy.
module fetch_unit_rv32_chk #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic       clk,
  input logic       rst,
  input logic [2:0] occ
);

  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
                                occ <= 3'(FIFO_DEPTH));

endmodule

// File: tb/tb_fetch_unit_rv32.sv
// Self-checking bench for fetch_unit_rv32: a cache model answers the
// registered address one cycle later with an address-derived word, and a
// scoreboard of expected PCs is refilled whenever reset or a redirect is
// driven, then popped on every accepted instruction.

module tb_fetch_unit_rv32;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        iRST;
  logic [31:0] oINSTADDR;
  logic [31:0] iINSTDATA;
  logic        iStallI;
  logic        iREDIRECT;
  logic [31:0] iREDIRECTPC;
  logic        iStallD;
  logic        oVALID;
  logic [31:0] oINSTR;
  logic [31:0] oPC;
  logic        oMISALIGN;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pop = 0;
  logic [31:0] exp_q [$];
  logic [31:0] cache_addr_q = 32'd0;

  fetch_unit_rv32 #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .iCLK        (clk),
    .iRST        (iRST),
    .oINSTADDR   (oINSTADDR),
    .iINSTDATA   (iINSTDATA),
    .iStallI     (iStallI),
    .iREDIRECT   (iREDIRECT),
    .iREDIRECTPC (iREDIRECTPC),
    .iStallD     (iStallD),
    .oVALID      (oVALID),
    .oINSTR      (oINSTR),
    .oPC         (oPC),
    .oMISALIGN   (oMISALIGN)
  );

  always #5 clk = ~clk;

  // Instruction word the cache returns for a given byte address.
  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Cache model: registers the word address, returns data next cycle.
  always @(posedge clk) cache_addr_q <= oINSTADDR;
  assign iINSTDATA = tag_of({cache_addr_q[29:0], 2'b00});

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic sb_refill(input logic [31:0] start);
    logic [31:0] p;
    exp_q.delete();
    p = start;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // Compare accepted instruction against scoreboard, then apply flushes.
  task automatic monitor();
    logic [31:0] e;
    if (!iRST && oVALID === 1'b1 && !iStallD) begin
      check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("opc", oPC, e);
        check("oinstr", oINSTR, tag_of(e));
        n_pop++;
      end
    end
    if (iRST) begin
      sb_refill(RESET_PC);
    end else if (iREDIRECT) begin
      sb_refill({iREDIRECTPC[31:2], 2'b00});
    end
  endtask

  // One cycle: inputs were set at the negedge, sample, advance.
  task automatic cyc();
    #2;
    monitor();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    iRST        = 1'b1;
    iREDIRECT   = 1'b0;
    iREDIRECTPC = 32'd0;
    iStallI     = 1'b0;
    iStallD     = 1'b0;
    @(negedge clk);

    // Reset, then free run
    run(3);
    iRST  = 1'b0;
    n_pop = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("addr_seq", oINSTADDR, 32'(k));
      check("valid_start", {31'd0, oVALID}, {31'd0, (k >= 2)});
      check("misalign_idle", {31'd0, oMISALIGN}, 32'd0);
      cyc();
    end
    check("pops_free", 32'(n_pop), 32'd8);

    // Decode stall for 5 cycles: head held, issue stops
    for (int k = 0; k < 5; k++) begin
      iStallD = 1'b1;
      #1;
      check("hold_valid", {31'd0, oVALID}, 32'd1);
      check("hold_pc", oPC, exp_q[0]);
      check("hold_instr", oINSTR, tag_of(exp_q[0]));
      check("issue_stop", oINSTADDR, (exp_q[0] + 32'd8) >> 2);
      cyc();
    end
    iStallD = 1'b0;
    n_pop   = 0;
    run(8);
    check("pops_release", 32'(n_pop), 32'd8);

    // Cache stall on request for PC 0x10
    iRST = 1'b1;
    run(2);
    iRST = 1'b0;
    run(5);
    for (int k = 0; k < 3; k++) begin
      iStallI = 1'b1;
      #1;
      check("stalli_addr", oINSTADDR, 32'd4);
      cyc();
    end
    iStallI = 1'b0;
    #1;
    check("stalli_resume", oINSTADDR, 32'd5);
    run(10);

    // Redirect to 0x100 with FIFO holding two entries
    iStallD = 1'b1;
    run(2);
    iREDIRECT   = 1'b1;
    iREDIRECTPC = 32'h0000_0100;
    cyc();
    iREDIRECT = 1'b0;
    iStallD   = 1'b0;
    #1;
    check("redir_valid0", {31'd0, oVALID}, 32'd0);
    check("redir_addr", oINSTADDR, 32'h0000_0040);
    check("redir_nomis", {31'd0, oMISALIGN}, 32'd0);
    cyc();
    #1;
    check("redir_valid1", {31'd0, oVALID}, 32'd0);
    cyc();
    #1;
    check("redir_valid2", {31'd0, oVALID}, 32'd1);
    run(8);

    // Misaligned redirect target 0x203
    iREDIRECT   = 1'b1;
    iREDIRECTPC = 32'h0000_0203;
    cyc();
    iREDIRECT = 1'b0;
    #1;
    check("mis_pulse", {31'd0, oMISALIGN}, 32'd1);
    check("mis_addr", oINSTADDR, 32'h0000_0080);
    cyc();
    #1;
    check("mis_clear", {31'd0, oMISALIGN}, 32'd0);
    run(6);

    // Reset and redirect together: reset wins
    iRST        = 1'b1;
    iREDIRECT   = 1'b1;
    iREDIRECTPC = 32'h0000_0403;
    cyc();
    iRST      = 1'b0;
    iREDIRECT = 1'b0;
    #1;
    check("rst_win_addr", oINSTADDR, RESET_PC >> 2);
    check("rst_win_mis", {31'd0, oMISALIGN}, 32'd0);
    check("rst_win_valid", {31'd0, oVALID}, 32'd0);
    run(8);

    // PC wrap past 0xFFFF_FFFC
    iREDIRECT   = 1'b1;
    iREDIRECTPC = 32'hFFFF_FFF8;
    cyc();
    iREDIRECT = 1'b0;
    n_pop     = 0;
    #1;
    check("wrap_addr", oINSTADDR, 32'h3FFF_FFFE);
    run(8);
    check("pops_wrap", 32'(n_pop), 32'd6);

    run(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
